draw_layer_arbiter: RTL
=======================

Name: draw_layer_arbiter

Overview:
- Per-pixel arbiter for the screen's drawable objects (ball, flippers, bumpers, walls). Each object is driven by a square-object drawing stage with a registered draw/RGB output.
- Selects the highest-priority requester drawing at the current pixel and drives the single RGB stream to the VGA controller.
- Accumulates ball-vs-object overlaps over one frame and publishes them once per frame as collision flags for the game-logic controller.

Parameters:
- NUM_OBJECTS, 4, number of requesters. Index 0 is the ball and has the highest priority. Priority falls with increasing index. Legal range 2..16.
- HIT_THRESHOLD, 4, minimum overlapped pixels per frame to report a hit. Used only with DRAW_ARB_HIT_COUNT_EN.

Ports:
- clk  in  1  pixel clock
- resetN  in  1  asynchronous, active-low reset
- startOfFrame  in  1  one-cycle pulse at the first pixel of each frame
- drawReq  in  NUM_OBJECTS  per-object draw flag, aligned with rgbIn
- rgbIn  in  8*NUM_OBJECTS  per-object colour; object i occupies bits [8i+7:8i]
- bgRGB  in  8  background colour
- rgbOut  out  8  arbitrated pixel colour
- drawAny  out  1  some object won this pixel
- grantIdx  out  4  index of the winning object; 0 when drawAny=0
- collision  out  NUM_OBJECTS-1  bit i-1 set means the ball overlapped object i in the last complete frame
- collisionValid  out  1  one-cycle pulse when collision is updated

Behaviour:
- Reset (asynchronous): rgbOut=COLOR_DEFAULT, drawAny=0, grantIdx=0, collision=0, collisionValid=0, FSM=WAIT_FIRST, accumulators cleared.
- Arbitration latency is exactly 1 clock, with registered outputs:
  - The winner is the lowest index with drawReq set. rgbOut takes that object's rgbIn, drawAny=1, grantIdx=index.
  - If no drawReq is set: rgbOut=bgRGB, drawAny=0, grantIdx=0.
  - rgbIn of a requester is used only when its drawReq=1. An rgbIn value equal to COLOR_TRANSPARENT with drawReq=1 still wins.
- Hit detection: in each cycle with drawReq[0]=1 and drawReq[i]=1 (i≥1), the overlap for object i is recorded in an internal accumulator hitAcc[i].
- FSM, 2 states:
  - WAIT_FIRST: hitAcc is held at 0. On startOfFrame go to ACCUM with no publish, because the frame before reset was partial.
  - ACCUM: hitAcc accumulates. On startOfFrame:
    - collision <= hitAcc status; collisionValid pulses 1 cycle (registered, appears the clock after the startOfFrame cycle).
    - hitAcc restarts. The pixel in the startOfFrame cycle belongs to the new frame: if it overlaps, the new hitAcc starts already set/at count 1.
- collision holds its value between publishes and never changes mid-frame.
- startOfFrame pulses on consecutive cycles: each one publishes. A 1-cycle frame is legal and publishes its single-pixel result.
- Reset mid-frame: outputs and FSM return immediately to their reset values. The first subsequent startOfFrame does not publish.
- Arbitration is independent of the FSM state and runs from the first clock after reset.

Optional Feature:
- Macro: DRAW_ARB_HIT_COUNT_EN.
- Defined: hitAcc[i] is a saturating counter of width clog2(HIT_THRESHOLD+1). At publish, collision bit = (count ≥ HIT_THRESHOLD). This filters single-pixel corner grazes.
- Undefined: hitAcc[i] is a single sticky bit. Any one overlapped pixel reports a hit. HIT_THRESHOLD is ignored.

Decomposition:
- Package defines: COLOR_TRANSPARENT and COLOR_DEFAULT (existing), plus new constants:
  - MAX_OBJECTS = 16
  - OBJ_IDX_W = 4
  - OBJ_BALL_IDX = 0
  - typedef arb_state_t {WAIT_FIRST, ACCUM}
- One natural sub-module, hit_accumulator: one instance per object 1..NUM_OBJECTS-1. It takes hit, startOfFrame, enable and threshold, and returns the published bit. The macro is handled inside it.

Test Plan:
- Priority: drawReq=4'b0110, rgbIn[1]=8'hE0, rgbIn[2]=8'h1C, bgRGB=8'h00 → next cycle rgbOut=8'hE0, grantIdx=1, drawAny=1. Then drawReq=0 → rgbOut=8'h00, drawAny=0, grantIdx=0.
- First-frame suppression: after reset, drawReq=4'b0011 for 10 cycles, then startOfFrame → collisionValid stays 0 and collision=0. Next frame has no overlap, then startOfFrame → collisionValid pulses with collision=3'b000.
- Hit publish: frame with 2 overlapped pixels of ball and object 3 → at the next startOfFrame, collision=3'b100, collisionValid high exactly 1 cycle, value held all following frame. With DRAW_ARB_HIT_COUNT_EN and HIT_THRESHOLD=4 → collision=3'b000. Repeat with 6 pixels → 3'b100.
- Frame-boundary overlap: overlap asserted only in the startOfFrame cycle → it is not in the current publish, and appears at the following publish.
- Async reset mid-frame: during accumulation with hits pending, pulse resetN low between clock edges → collision=0 and rgbOut=COLOR_DEFAULT immediately. The next startOfFrame does not publish.
- Counter saturation (macro on): ball and object 1 overlap for 10000 pixels in one frame → collision[0]=1 with no wrap. The next clean frame publishes 0.

Source files
------------

// File: rtl/draw_layer_arbiter_pkg.sv
// Shared constants and types for the draw-layer arbiter slice.
package draw_layer_arbiter_pkg;

    localparam logic [7:0] COLOR_TRANSPARENT = 8'hFF;
    localparam logic [7:0] COLOR_DEFAULT     = 8'h00;

    localparam int unsigned MAX_OBJECTS  = 16;
    localparam int unsigned OBJ_IDX_W    = 4;
    localparam int unsigned OBJ_BALL_IDX = 0;

    typedef enum logic {
        WAIT_FIRST,
        ACCUM
    } arb_state_t;

endpackage

// File: rtl/draw_layer_arbiter_if.sv
// Pixel bus between the square-object drawing stages and the layer arbiter.
interface draw_layer_arbiter_if #(
    parameter int unsigned NUM_OBJECTS = 4
);
    import draw_layer_arbiter_pkg::*;

    logic                       startOfFrame;
    logic [NUM_OBJECTS-1:0]     drawReq;
    logic [8*NUM_OBJECTS-1:0]   rgbIn;
    logic [7:0]                 bgRGB;
    logic [7:0]                 rgbOut;
    logic                       drawAny;
    logic [OBJ_IDX_W-1:0]       grantIdx;
    logic [NUM_OBJECTS-2:0]     collision;
    logic                       collisionValid;

    modport master (
        output startOfFrame, drawReq, rgbIn, bgRGB,
        input  rgbOut, drawAny, grantIdx, collision, collisionValid
    );

    modport slave (
        input  startOfFrame, drawReq, rgbIn, bgRGB,
        output rgbOut, drawAny, grantIdx, collision, collisionValid
    );

endinterface

// File: rtl/draw_layer_arbiter_hit_accumulator.sv
// Per-object ball-overlap accumulator; publishes its frame result on startOfFrame.
// DRAW_ARB_HIT_COUNT_EN: saturating overlap counter compared to HIT_THRESHOLD instead of a sticky bit.
module draw_layer_arbiter_hit_accumulator #(
    parameter int unsigned HIT_THRESHOLD = 4
) (
    input  logic clk,
    input  logic resetN,
    input  logic hit,
    input  logic startOfFrame,
    input  logic enable,
    output logic collision
);

    if (HIT_THRESHOLD < 1) begin : g_bad_threshold
        $error("HIT_THRESHOLD must be at least 1");
    end

    logic acc_hit;
    logic collision_q, collision_d;

`ifdef DRAW_ARB_HIT_COUNT_EN
    localparam int unsigned CNT_W = $clog2(HIT_THRESHOLD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HIT_THRESHOLD);

    logic [CNT_W-1:0] acc_q, acc_d;

    assign acc_hit = (acc_q >= CNT_MAX);

    // The startOfFrame pixel already belongs to the new frame.
    always_comb begin
        acc_d = acc_q;
        if (startOfFrame)
            acc_d = hit ? CNT_W'(1) : '0;
        else if (!enable)
            acc_d = '0;
        else if (hit && (acc_q != CNT_MAX))
            acc_d = acc_q + CNT_W'(1);
    end
`else
    logic acc_q, acc_d;

    assign acc_hit = acc_q;

    always_comb begin
        acc_d = startOfFrame ? hit : (enable & (acc_q | hit));
    end
`endif

    always_comb begin
        collision_d = collision_q;
        if (startOfFrame && enable)
            collision_d = acc_hit;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            acc_q       <= '0;
            collision_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            collision_q <= collision_d;
        end
    end

    assign collision = collision_q;

endmodule

// File: rtl/draw_layer_arbiter.sv
// Per-pixel priority arbiter for drawable objects (index 0 = ball, highest priority)
// with once-per-frame ball collision publishing. Optional macro: DRAW_ARB_HIT_COUNT_EN.
module draw_layer_arbiter
    import draw_layer_arbiter_pkg::*;
#(
    parameter int unsigned NUM_OBJECTS   = 4,
    parameter int unsigned HIT_THRESHOLD = 4
) (
    input logic                 clk,
    input logic                 resetN,
    draw_layer_arbiter_if.slave bus
);

    if ((NUM_OBJECTS < 2) || (NUM_OBJECTS > MAX_OBJECTS)) begin : g_bad_num_objects
        $error("NUM_OBJECTS must be in 2..16");
    end

    arb_state_t state_q, state_d;
    logic       accum_en;
    logic       publish;

    logic [7:0]            rgb_out_q, rgb_out_d;
    logic                  draw_any_q, draw_any_d;
    logic [OBJ_IDX_W-1:0]  grant_idx_q, grant_idx_d;
    logic                  collision_valid_q, collision_valid_d;
    logic [NUM_OBJECTS-2:0] collision_w;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            state_q <= WAIT_FIRST;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_FIRST: if (bus.startOfFrame) state_d = ACCUM;
            ACCUM:      state_d = ACCUM;
            default:    state_d = WAIT_FIRST;
        endcase
    end

    // The frame cut short by reset is never published.
    always_comb begin
        accum_en = (state_q == ACCUM);
        publish  = accum_en && bus.startOfFrame;
    end

    always_comb begin
        rgb_out_d   = bus.bgRGB;
        draw_any_d  = 1'b0;
        grant_idx_d = '0;
        for (int unsigned i = 0; i < NUM_OBJECTS; i++) begin
            if (!draw_any_d && bus.drawReq[i]) begin
                rgb_out_d   = bus.rgbIn[8*i +: 8];
                draw_any_d  = 1'b1;
                grant_idx_d = OBJ_IDX_W'(i);
            end
        end
        collision_valid_d = publish;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rgb_out_q         <= COLOR_DEFAULT;
            draw_any_q        <= 1'b0;
            grant_idx_q       <= '0;
            collision_valid_q <= 1'b0;
        end else begin
            rgb_out_q         <= rgb_out_d;
            draw_any_q        <= draw_any_d;
            grant_idx_q       <= grant_idx_d;
            collision_valid_q <= collision_valid_d;
        end
    end

    for (genvar g = 1; g < NUM_OBJECTS; g++) begin : g_hit
        draw_layer_arbiter_hit_accumulator #(
            .HIT_THRESHOLD(HIT_THRESHOLD)
        ) u_acc (
            .clk          (clk),
            .resetN       (resetN),
            .hit          (bus.drawReq[OBJ_BALL_IDX] & bus.drawReq[g]),
            .startOfFrame (bus.startOfFrame),
            .enable       (accum_en),
            .collision    (collision_w[g-1])
        );
    end

    assign bus.rgbOut         = rgb_out_q;
    assign bus.drawAny        = draw_any_q;
    assign bus.grantIdx       = grant_idx_q;
    assign bus.collision      = collision_w;
    assign bus.collisionValid = collision_valid_q;

endmodule
